quire_multichannel: RTL and testbench

- Parametrised successor to the single-window quire accumulator.
- Holds NB_CHANNELS independent quires. Each one accumulates exact posit products (or posits) over its own sow/eow window.
- Input is a single shared denormalised-operand stream tagged with a channel id. Output is a round-robin stream of finished quire results.
- Sits between the posit multiplier/denormaliser and the quire-to-posit normaliser.

---
 rtl/quire_multichannel.sv | 183 ++++++++++++++++++
 tb/tb_quire_multichannel.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/quire_multichannel.sv
// Multi-channel quire accumulator: a shared, channel-tagged operand stream feeds
// NB_CHANNELS independent quires; finished windows leave through one
// round-robin arbitrated output register.
module quire_multichannel #(
  parameter int POSIT_WIDTH   = 8,
  parameter int POSIT_ES      = 0,
  parameter int LOG_NB_ACCUM  = 15,
  parameter int IS_PROD_ACCUM = 1,
  parameter int NB_CHANNELS   = 4,
  parameter int FRAC_W        = (IS_PROD_ACCUM != 0 ? 2 : 1) * (POSIT_WIDTH - 2 - POSIT_ES),
  parameter int SCALE_W       = $clog2((IS_PROD_ACCUM != 0 ? 2 : 1) * (POSIT_WIDTH - 2) * (2 ** POSIT_ES) + 1) + 1,
  parameter int QUIRE_W       = (2 ** (POSIT_ES + 2)) * (POSIT_WIDTH - 2) + 2 + LOG_NB_ACCUM,
  parameter int CH_W          = (NB_CHANNELS > 1) ? $clog2(NB_CHANNELS) : 1
) (
  input  logic               clk,
  input  logic               rst,
  output logic               rtr_o,
  input  logic               rts_i,
  input  logic               sow_i,
  input  logic               eow_i,
  input  logic [CH_W-1:0]    ch_i,
  input  logic [FRAC_W-1:0]  fraction,
  input  logic [SCALE_W-1:0] scale,
  input  logic               zero_i,
  input  logic               sign_i,
  input  logic               NaR_i,
  input  logic               rtr_i,
  output logic               rts_o,
  output logic [CH_W-1:0]    ch_o,
  output logic               nar_o,
  output logic [QUIRE_W-1:0] data_o
);

  localparam int QFRAC = (IS_PROD_ACCUM != 0 ? 2 : 1) * (POSIT_WIDTH - 2) * (2 ** POSIT_ES);

  typedef enum logic [1:0] {ST_IDLE, ST_ACCUM, ST_PENDING} ch_state_t;

  // Captured operand (handshake edge)
  logic               in_valid, in_sow, in_eow, in_zero, in_sign, in_nar;
  logic [CH_W-1:0]    in_ch;
  logic [FRAC_W-1:0]  in_frac;
  logic [SCALE_W-1:0] in_scale;

  // Aligned operand
  logic               s1_valid, s1_sow, s1_eow, s1_nar;
  logic [CH_W-1:0]    s1_ch;
  logic [QUIRE_W-1:0] s1_val;

  // Per-channel quire state
  ch_state_t          ch_state [NB_CHANNELS];
  logic [QUIRE_W-1:0] acc      [NB_CHANNELS];
  logic               nar_flag [NB_CHANNELS];

  logic [CH_W-1:0]    last_grant;
  logic [CH_W-1:0]    grant;
  logic               any_pend, load, grant_nar, blocked;
  logic [QUIRE_W-1:0] grant_acc;
  logic [QUIRE_W-1:0] aligned, mag, ext;
  int                 sh;

  // Accept unless the target channel is pending or an eow for it is still in flight
  always_comb begin
    blocked = 1'b0;
    for (int unsigned i = 0; i < NB_CHANNELS; i++)
      if (CH_W'(i) == ch_i && ch_state[i] == ST_PENDING) blocked = 1'b1;
    if (in_valid && in_eow && in_ch == ch_i) blocked = 1'b1;
    if (s1_valid && s1_eow && s1_ch == ch_i) blocked = 1'b1;
    rtr_o = !rst && !blocked;
  end

  // Align the captured operand to the quire fixed point and apply its sign
  always_comb begin
    sh  = int'($signed(in_scale)) + QFRAC - (FRAC_W - 1);
    ext = QUIRE_W'(in_frac);
    if (sh >= 0) mag = ext << sh;
    else         mag = ext >> (-sh);
    aligned = in_sign ? -mag : mag;
    if (in_zero || in_nar) aligned = '0;
  end

  // Round-robin pick of a pending channel, searching after the last grant
  always_comb begin
    int unsigned idx;
    any_pend  = 1'b0;
    grant     = '0;
    grant_acc = '0;
    grant_nar = 1'b0;
    idx       = 0;
    for (int unsigned off = 1; off <= NB_CHANNELS; off++) begin
      idx = (32'(last_grant) + off) % 32'(NB_CHANNELS);
      if (!any_pend && ch_state[idx] == ST_PENDING) begin
        any_pend  = 1'b1;
        grant     = CH_W'(idx);
        grant_acc = acc[idx];
        grant_nar = nar_flag[idx];
      end
    end
    load = any_pend && (!rts_o || rtr_i);
  end

  // Operand capture and alignment stage; a capture register precedes the
  // alignment register so that the eow-to-result latency stays three edges
  always_ff @(posedge clk) begin
    if (rst) begin
      in_valid <= 1'b0;
      in_sow   <= 1'b0;
      in_eow   <= 1'b0;
      in_zero  <= 1'b0;
      in_sign  <= 1'b0;
      in_nar   <= 1'b0;
      in_ch    <= '0;
      in_frac  <= '0;
      in_scale <= '0;
      s1_valid <= 1'b0;
      s1_sow   <= 1'b0;
      s1_eow   <= 1'b0;
      s1_nar   <= 1'b0;
      s1_ch    <= '0;
      s1_val   <= '0;
    end else begin
      in_valid <= rts_i && rtr_o;
      in_sow   <= sow_i;
      in_eow   <= eow_i;
      in_zero  <= zero_i;
      in_sign  <= sign_i;
      in_nar   <= NaR_i;
      in_ch    <= ch_i;
      in_frac  <= fraction;
      in_scale <= scale;
      s1_valid <= in_valid;
      s1_sow   <= in_sow;
      s1_eow   <= in_eow;
      s1_nar   <= in_nar;
      s1_ch    <= in_ch;
      s1_val   <= aligned;
    end
  end

  // Per-channel accumulate and window state; granted channels return to idle
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
        ch_state[i] <= ST_IDLE;
        acc[i]      <= '0;
        nar_flag[i] <= 1'b0;
      end
    end else begin
      for (int unsigned i = 0; i < NB_CHANNELS; i++) begin
        if (load && grant == CH_W'(i)) ch_state[i] <= ST_IDLE;
        if (s1_valid && s1_ch == CH_W'(i)) begin
          if (s1_sow || ch_state[i] == ST_IDLE) begin
            acc[i]      <= s1_val;
            nar_flag[i] <= s1_nar;
          end else begin
            acc[i]      <= acc[i] + s1_val;
            nar_flag[i] <= nar_flag[i] | s1_nar;
          end
          ch_state[i] <= s1_eow ? ST_PENDING : ST_ACCUM;
        end
      end
    end
  end

  // Output register: load a granted result, hold while stalled downstream
  always_ff @(posedge clk) begin
    if (rst) begin
      rts_o      <= 1'b0;
      ch_o       <= '0;
      nar_o      <= 1'b0;
      data_o     <= '0;
      last_grant <= CH_W'(NB_CHANNELS - 1);
    end else if (load) begin
      rts_o      <= 1'b1;
      ch_o       <= grant;
      nar_o      <= grant_nar;
      data_o     <= grant_nar ? {1'b1, {(QUIRE_W-1){1'b0}}} : grant_acc;
      last_grant <= grant;
    end else if (rtr_i) begin
      rts_o <= 1'b0;
    end
  end

endmodule

// File: tb/tb_quire_multichannel.sv
// Directed bench for quire_multichannel (N=8, ES=0, products, 4 channels).
module tb_quire_multichannel;

  localparam int QW = 41;

  localparam logic [11:0] F1   = 12'h800;
  localparam logic [4:0]  S0   = 5'd0;
  localparam logic [4:0]  S1   = 5'd1;
  localparam logic [4:0]  SM1  = 5'h1F;
  localparam logic [4:0]  SMIN = 5'h14;
  localparam logic [4:0]  SMAX = 5'h0C;

  logic tb_clk = 1'b0;
  logic tb_rst;
  logic rtr_o, rts_i, sow_i, eow_i, zero_i, sign_i, nar_i, rtr_i, rts_o, nar_o;
  logic [1:0]    ch_i, ch_o;
  logic [11:0]   fraction;
  logic [4:0]    scale;
  logic [QW-1:0] data_o;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [1:0]    ch;
    logic          sow, eow;
    logic [11:0]   frac;
    logic [4:0]    sc;
    logic          zero, sign, nar;
    logic          exp_nar;
    logic [QW-1:0] exp_data;
  } vec_t;

  typedef struct {
    logic [1:0]    ch;
    logic          nar;
    logic [QW-1:0] data;
  } res_t;

  vec_t vecs[$];
  res_t exp_q[$];

  always #5 tb_clk = ~tb_clk;

  quire_multichannel #(
    .POSIT_WIDTH(8),
    .POSIT_ES(0),
    .LOG_NB_ACCUM(15),
    .IS_PROD_ACCUM(1),
    .NB_CHANNELS(4)
  ) dut (
    .clk(tb_clk), .rst(tb_rst), .rtr_o(rtr_o), .rts_i(rts_i),
    .sow_i(sow_i), .eow_i(eow_i), .ch_i(ch_i), .fraction(fraction),
    .scale(scale), .zero_i(zero_i), .sign_i(sign_i), .NaR_i(nar_i),
    .rtr_i(rtr_i), .rts_o(rts_o), .ch_o(ch_o), .nar_o(nar_o), .data_o(data_o)
  );

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", nm, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [1:0] ch, input logic sow, input logic eow,
                              input logic [11:0] frac, input logic [4:0] sc,
                              input logic zero, input logic sign, input logic nar,
                              input logic exp_nar, input logic [QW-1:0] exp_data);
    vec_t v;
    v.ch = ch; v.sow = sow; v.eow = eow; v.frac = frac; v.sc = sc;
    v.zero = zero; v.sign = sign; v.nar = nar;
    v.exp_nar = exp_nar; v.exp_data = exp_data;
    return v;
  endfunction

  function automatic res_t mkres(input logic [1:0] ch, input logic nar, input logic [QW-1:0] data);
    res_t r;
    r.ch = ch; r.nar = nar; r.data = data;
    return r;
  endfunction

  // Present one beat and hold it until accepted (bounded); optionally queue its result
  task automatic drive_beat(input vec_t v, input bit push, output int stalls);
    stalls = 0;
    @(negedge tb_clk);
    ch_i = v.ch; sow_i = v.sow; eow_i = v.eow; fraction = v.frac; scale = v.sc;
    zero_i = v.zero; sign_i = v.sign; nar_i = v.nar; rts_i = 1'b1;
    #1;
    while (!rtr_o) begin
      stalls++;
      if (stalls > 100) begin
        checks++; errors++;
        $display("FAIL beat_accept_timeout ch=%0d actual=stalled required=accepted", v.ch);
        rts_i = 1'b0;
        return;
      end
      @(negedge tb_clk);
      #1;
    end
    @(posedge tb_clk);
    #1;
    rts_i = 1'b0;
    if (push && v.eow) exp_q.push_back(mkres(v.ch, v.exp_nar, v.exp_data));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      @(posedge tb_clk);
      n++;
    end
    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain_timeout actual=%0d outstanding required=0", exp_q.size());
    end
    repeat (5) @(posedge tb_clk);
  endtask

  // Result monitor: every accepted result must match the next expected one
  always @(negedge tb_clk) begin
    if (!tb_rst && rts_o && rtr_i) begin
      if (exp_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL unexpected_result actual ch=%0d data=%h required=none", ch_o, data_o);
      end else begin
        res_t e;
        e = exp_q.pop_front();
        check("res_ch", 64'(ch_o), 64'(e.ch));
        check("res_nar", 64'(nar_o), 64'(e.nar));
        check("res_data", 64'(data_o), 64'(e.data));
      end
    end
  end

  initial begin
    int st, tot;
    vec_t v;

    // Directed windows
    vecs.push_back(mk(2'd1, 1, 0, F1, S1,   0, 0, 0, 0, '0));
    vecs.push_back(mk(2'd2, 1, 0, F1, S0,   0, 1, 0, 0, '0));
    vecs.push_back(mk(2'd1, 0, 1, F1, SM1,  0, 1, 0, 0, 41'h1800));
    vecs.push_back(mk(2'd2, 0, 1, F1, S0,   0, 0, 0, 0, 41'h0));
    vecs.push_back(mk(2'd3, 1, 0, F1, S0,   0, 0, 0, 0, '0));
    vecs.push_back(mk(2'd3, 0, 0, '0, S0,   0, 0, 1, 0, '0));
    vecs.push_back(mk(2'd3, 0, 1, F1, S0,   0, 0, 0, 1, 41'h100_0000_0000));
    vecs.push_back(mk(2'd3, 1, 1, F1, S0,   0, 0, 0, 0, 41'h1000));
    for (int i = 0; i < 8; i++)
      vecs.push_back(mk(2'd0, (i == 0), 0, F1, SMIN, 0, 0, 0, 0, '0));
    vecs.push_back(mk(2'd0, 0, 0, F1, SMAX, 1, 0, 0, 0, '0));
    vecs.push_back(mk(2'd0, 0, 1, F1, SMAX, 0, 0, 0, 0, 41'h100_0008));
    vecs.push_back(mk(2'd1, 0, 0, F1, S0,   0, 0, 0, 0, '0));
    vecs.push_back(mk(2'd1, 0, 1, F1, S0,   0, 0, 0, 0, 41'h2000));
    vecs.push_back(mk(2'd2, 1, 0, F1, S1,   0, 0, 0, 0, '0));
    vecs.push_back(mk(2'd2, 1, 0, F1, S0,   0, 0, 0, 0, '0));
    vecs.push_back(mk(2'd2, 0, 1, F1, S0,   0, 0, 0, 0, 41'h2000));
    vecs.push_back(mk(2'd1, 1, 1, F1, SM1,  0, 1, 0, 0, 41'h1FF_FFFF_F800));

    tb_rst = 1'b1; rts_i = 1'b0; rtr_i = 1'b1; ch_i = '0; sow_i = 1'b0; eow_i = 1'b0;
    fraction = '0; scale = '0; zero_i = 1'b0; sign_i = 1'b0; nar_i = 1'b0;
    repeat (3) @(posedge tb_clk);
    #1;
    check("reset_rtr_o", 64'(rtr_o), 64'd0);
    check("reset_rts_o", 64'(rts_o), 64'd0);
    check("reset_ch_o", 64'(ch_o), 64'd0);
    check("reset_nar_o", 64'(nar_o), 64'd0);
    check("reset_data_o", 64'(data_o), 64'd0);
    tb_rst = 1'b0;
    #1;
    check("post_reset_rtr_o", 64'(rtr_o), 64'd1);

    // Four +1.0 products on ch0 and the eow-to-result latency
    for (int i = 0; i < 4; i++)
      drive_beat(mk(2'd0, (i == 0), (i == 3), F1, S0, 0, 0, 0, 0, 41'h4000), 1'b1, st);
    repeat (3) @(negedge tb_clk);
    check("latency_not_early", 64'(rts_o), 64'd0);
    @(negedge tb_clk);
    check("latency_k3", 64'(rts_o), 64'd1);
    wait_drain();

    // Table of windows; the first four beats interleave ch1/ch2 and must not stall
    tot = 0;
    for (int i = 0; i < vecs.size(); i++) begin
      drive_beat(vecs[i], 1'b1, st);
      if (i < 4) tot += st;
      if (i == 3) check("interleave_no_stall", 64'(tot), 64'd0);
    end
    wait_drain();

    // Backpressure: windows end on ch3, ch2, ch1 while the output is stalled
    @(posedge tb_clk); #1 tb_rst = 1'b1;
    @(posedge tb_clk); #1 tb_rst = 1'b0; rtr_i = 1'b0;
    drive_beat(mk(2'd3, 1, 1, F1, SM1, 0, 1, 0, 0, '0), 1'b0, st);
    drive_beat(mk(2'd2, 1, 1, F1, S1,  0, 0, 0, 0, '0), 1'b0, st);
    drive_beat(mk(2'd1, 1, 1, F1, S0,  0, 0, 0, 0, '0), 1'b0, st);
    repeat (3) @(negedge tb_clk);
    for (int i = 0; i < 4; i++) begin
      @(negedge tb_clk);
      check("hold_rts_o", 64'(rts_o), 64'd1);
      check("hold_ch_o", 64'(ch_o), 64'd3);
      check("hold_data_o", 64'(data_o), 64'h1FF_FFFF_F800);
    end
    ch_i = 2'd2; #1 check("rtr_o_pending_ch2", 64'(rtr_o), 64'd0);
    ch_i = 2'd1; #1 check("rtr_o_pending_ch1", 64'(rtr_o), 64'd0);
    ch_i = 2'd3; #1 check("rtr_o_free_ch3", 64'(rtr_o), 64'd1);
    ch_i = 2'd0; #1 check("rtr_o_free_ch0", 64'(rtr_o), 64'd1);
    exp_q.push_back(mkres(2'd3, 1'b0, 41'h1FF_FFFF_F800));
    exp_q.push_back(mkres(2'd1, 1'b0, 41'h1000));
    exp_q.push_back(mkres(2'd2, 1'b0, 41'h2000));
    @(posedge tb_clk); #1 rtr_i = 1'b1;
    wait_drain();

    // Reset mid-window on ch0 with ch1 pending behind a stalled ch2 result
    @(posedge tb_clk); #1 rtr_i = 1'b0;
    drive_beat(mk(2'd2, 1, 1, F1, S0, 0, 0, 0, 0, '0), 1'b0, st);
    drive_beat(mk(2'd1, 1, 1, F1, S0, 0, 0, 0, 0, '0), 1'b0, st);
    drive_beat(mk(2'd0, 1, 0, F1, S0, 0, 0, 0, 0, '0), 1'b0, st);
    repeat (4) @(posedge tb_clk);
    #1;
    check("pre_reset_rts_o", 64'(rts_o), 64'd1);
    ch_i = 2'd0;
    tb_rst = 1'b1;
    #1 check("rtr_o_in_reset", 64'(rtr_o), 64'd0);
    @(posedge tb_clk); #1;
    check("mid_reset_rts_o", 64'(rts_o), 64'd0);
    tb_rst = 1'b0; rtr_i = 1'b1;
    repeat (4) @(posedge tb_clk);
    #1;
    check("ch1_result_lost", 64'(rts_o), 64'd0);
    ch_i = 2'd1;
    #1 check("ch1_not_pending", 64'(rtr_o), 64'd1);
    v = mk(2'd0, 1, 1, F1, S0, 0, 0, 0, 0, 41'h1000);
    drive_beat(v, 1'b1, st);
    wait_drain();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
